seg7_scan: RTL and testbench
============================

# seg7_scan

Parametrised multiplexed seven-segment display driver for the board's common-cathode/anode digit banks. It holds one 5-bit value (hex nibble + decimal point) per digit and time-multiplexes the digits with a programmable scan period and anti-ghosting blank interval. It decodes each value to segments internally and drives a registered segment bus and a one-hot digit-select bus. The block sits between the system register interface and the board pins, replacing per-digit static decoding.

## Interface
- NUM_DIGITS, 6: number of digits scanned (2..16).
- SCAN_DIV, 50000: clock cycles per digit slot (≥ BLANK_CYC+2).
- BLANK_CYC, 16: cycles at start of each slot with all digits off (0 disables blanking).
- SEG_ACT_LOW, 0: 1 inverts every `seg` bit at the output.
- CTRL_ACT_LOW, 0: 1 inverts every `ctrl` bit at the output.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe for the digit register file.
- wr_addr  input  $clog2(NUM_DIGITS)  digit index to write.
- wr_data  input  5  [3:0] hex value, [4] decimal point.
- seg  output  8  segments, [7]=a … [1]=g, [0]=dp, registered.
- ctrl  output  NUM_DIGITS  digit select, bit i = digit i, registered.
- frame_tick  output  1  one-cycle pulse at the start of each full scan frame.

## Operation
- Digit register file: NUM_DIGITS × 5 bits. Reset value 0. On `wr_en`, entry `wr_addr` <= `wr_data`. Writes with `wr_addr` ≥ NUM_DIGITS are ignored, with no state change.
- Slot counter `cnt` (0..SCAN_DIV-1) and digit index `idx` (0..NUM_DIGITS-1), both reset to 0.
  - `cnt` increments every cycle.
  - At `cnt`==SCAN_DIV-1, `cnt` goes to 0 and `idx` increments, wrapping NUM_DIGITS-1 to 0.
- Output register update each edge, from the pre-edge `cnt`, `idx` and register file:
  - If `cnt` < BLANK_CYC: `ctrl` all inactive, `seg` all inactive.
  - Otherwise: `ctrl` one-hot at `idx`; `seg` = hex decode of entry[`idx`][3:0] with dp = entry[`idx`][4].
- Decode: standard hex 0–F. Active-high examples:
  - 0 → 8'b1111_1100
  - 1 → 8'b0110_0000
  - 3 → 8'b1111_0010
  - 8 → 8'b1111_1110
  - A → 8'b1110_1110
  - F → 8'b1000_1110
- Polarity: SEG_ACT_LOW and CTRL_ACT_LOW invert the final registered values, including reset and blank values. "Inactive" means logic 0 before inversion.
- Reset (asynchronous, any time, including mid-slot):
  - `seg` and `ctrl` go inactive immediately.
  - `frame_tick`=0; `cnt`=0, `idx`=0; register file cleared.
  - Scanning restarts at digit 0 with a full blank interval.

## Timing
- Output latency: 1 cycle from counter state to `seg`/`ctrl`.
- Write to the currently displayed digit: new segments visible on the 2nd rising edge after the `wr_en` edge. A write on the same edge as a slot change is stored; no corruption.
- Slot length exactly SCAN_DIV cycles; frame length NUM_DIGITS × SCAN_DIV cycles.
- `frame_tick` is high for exactly one cycle, registered: it is asserted on the edge where `idx` wraps to 0. The first frame after reset produces no tick.
- `ctrl` never has more than one active bit. No cycle shows one digit's segments with another digit's select.
- BLANK_CYC=0: no blank cycles; `ctrl` changes digit the cycle after the slot wrap.

## Structure
- Package `seg7_pkg`:
  - segment bit index constants (SEG_A..SEG_G, SEG_DP);
  - 16-entry hex-to-segment constant table / function `hex2seg`;
  - the 5-bit digit value typedef.
- Sub-module `seg7_hex_dec`: combinational 4-bit + dp to 8-bit active-high decoder, instantiated once on the muxed entry. Polarity inversion stays in `seg7_scan`.

## Test plan
- Reset release, SCAN_DIV=20, BLANK_CYC=4, NUM_DIGITS=4, no writes:
  - `ctrl`=0 for 5 cycles after release, then 4'b0001 with `seg`=8'b1111_1100;
  - `ctrl` steps to 4'b0010 after 20 cycles.
- Write digit 2 = 5'h13 (3 + dp): `seg`=8'b1111_0011 for all non-blank cycles of slot 2 only.
- Write digit 1 while digit 1 is displayed, 5'h08 → 5'h0F: `seg` changes 8'b1111_1110 → 8'b1000_1110 exactly 2 edges after `wr_en`.
- `wr_addr`=5 with NUM_DIGITS=4: all entries unchanged across one frame.
- Over 3 frames: `frame_tick` pulses every 80 cycles, coinciding with `ctrl` going to digit 0's blank slot; `ctrl` is never multi-hot.
- Assert `rst` mid-slot on digit 3 with SEG_ACT_LOW=1:
  - `seg`=8'hFF and `ctrl`=0 asynchronously;
  - after release, digit 0 displays 8'b0000_0011 (0 inverted).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit positions,
// the per-digit storage type and the hex-to-segment table.
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  // Active-high segment pattern {a,b,c,d,e,f,g,dp}; dp is always 0 here.
  function automatic logic [7:0] hex2seg(input logic [3:0] hex);
    logic [6:0] abcdefg;
    abcdefg = 7'b000_0000;
    case (hex)
      4'h0: abcdefg = 7'b111_1110;
      4'h1: abcdefg = 7'b011_0000;
      4'h2: abcdefg = 7'b110_1101;
      4'h3: abcdefg = 7'b111_1001;
      4'h4: abcdefg = 7'b011_0011;
      4'h5: abcdefg = 7'b101_1011;
      4'h6: abcdefg = 7'b101_1111;
      4'h7: abcdefg = 7'b111_0000;
      4'h8: abcdefg = 7'b111_1111;
      4'h9: abcdefg = 7'b111_1011;
      4'hA: abcdefg = 7'b111_0111;
      4'hB: abcdefg = 7'b001_1111;
      4'hC: abcdefg = 7'b100_1110;
      4'hD: abcdefg = 7'b011_1101;
      4'hE: abcdefg = 7'b100_1111;
      4'hF: abcdefg = 7'b100_0111;
    endcase
    return {abcdefg, 1'b0};
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex + decimal-point to active-high segment decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] seg
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    seg         = hex2seg(hex);
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment driver: per-digit register file, slot/digit scan
// counters with a blank interval, and registered, polarity-adjusted pin outputs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int SEG_ACT_LOW  = 0,
  parameter int CTRL_ACT_LOW = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [4:0]                    wr_data,
  output logic [7:0]                    seg,
  output logic [NUM_DIGITS-1:0]         ctrl,
  output logic                          frame_tick
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0]         SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [AW-1:0]         IDX_LAST  = AW'(NUM_DIGITS - 1);
  localparam logic [AW:0]           DIG_LIM   = (AW + 1)'(NUM_DIGITS);
  localparam logic [7:0]            SEG_MASK  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] CTRL_MASK = (CTRL_ACT_LOW != 0) ? '1 : '0;

  logic [CW-1:0]         cnt;
  logic [AW-1:0]         idx;
  digit_t                regs [NUM_DIGITS];
  digit_t                cur;
  logic                  slot_end;
  logic                  in_blank;
  logic [7:0]            seg_dec;
  logic [7:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] ctrl_nxt;

  assign slot_end = (cnt == SLOT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // NOTE: the register file is small and must read back as zero after reset, so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) regs[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < DIG_LIM)) begin
      regs[wr_addr] <= digit_t'(wr_data);
    end
  end

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK_CYC));
    end
  endgenerate

  assign cur = regs[idx];

  seg7_hex_dec u_dec (
    .hex (cur.hex),
    .dp  (cur.dp),
    .seg (seg_dec)
  );

  // Segments and select come from the same pre-edge idx, so they always switch together.
  always_comb begin
    seg_nxt  = '0;
    ctrl_nxt = '0;
    if (!in_blank) begin
      seg_nxt       = seg_dec;
      ctrl_nxt[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_MASK;
      ctrl       <= CTRL_MASK;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt ^ SEG_MASK;
      ctrl       <= ctrl_nxt ^ CTRL_MASK;
      frame_tick <= slot_end && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: three instances cover the default polarity,
// inverted segments, and a 5-digit no-blank inverted-select configuration.
module tb_seg7_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic       wr_en_c = 1'b0;
  logic [2:0] wr_addr_c = '0;
  logic [4:0] wr_data_c = '0;

  logic [7:0] seg_a, seg_b, seg_c;
  logic [3:0] ctrl_a, ctrl_b;
  logic [4:0] ctrl_c;
  logic       tick_a, tick_b, tick_c;

  int n_assert = 0;
  int n_fail   = 0;
  int k        = 0;

  always #5 clk = ~clk;

  seg7_scan #(.NUM_DIGITS(4), .SCAN_DIV(20), .BLANK_CYC(4), .SEG_ACT_LOW(0), .CTRL_ACT_LOW(0)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seg(seg_a), .ctrl(ctrl_a), .frame_tick(tick_a));

  seg7_scan #(.NUM_DIGITS(4), .SCAN_DIV(20), .BLANK_CYC(4), .SEG_ACT_LOW(1), .CTRL_ACT_LOW(0)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seg(seg_b), .ctrl(ctrl_b), .frame_tick(tick_b));

  seg7_scan #(.NUM_DIGITS(5), .SCAN_DIV(20), .BLANK_CYC(0), .SEG_ACT_LOW(0), .CTRL_ACT_LOW(1)) u_dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .seg(seg_c), .ctrl(ctrl_c), .frame_tick(tick_c));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    k += n;
  endtask

  initial begin
    int n_ticks, bad_tick, multi, bad_blank, prev_tick, bad_c;

    repeat (2) @(negedge clk);
    check("rst_seg_a", seg_a, 8'h00);
    check("rst_ctrl_a", ctrl_a, 4'b0000);
    check("rst_seg_b", seg_b, 8'hFF);
    check("rst_ctrl_c", ctrl_c, 5'b11111);
    check("rst_ticks", {tick_a, tick_b, tick_c}, 3'b000);
    rst = 1'b0;
    k = 0;

    cyc(1);
    check("blank1_ctrl_a", ctrl_a, 4'b0000);
    check("noblank_ctrl_c", ctrl_c, 5'b11110);
    check("noblank_seg_c", seg_c, 8'hFC);
    for (int i = 2; i <= 4; i++) begin
      cyc(1);
      check("blank_ctrl_a", ctrl_a, 4'b0000);
      check("blank_seg_a", seg_a, 8'h00);
    end
    cyc(1);
    check("k5_ctrl_a", ctrl_a, 4'b0001);
    check("k5_seg_a", seg_a, 8'hFC);
    check("k5_ctrl_b", ctrl_b, 4'b0001);
    check("k5_seg_b", seg_b, 8'h03);
    cyc(15);
    check("k20_ctrl_a", ctrl_a, 4'b0001);
    check("k20_ctrl_c", ctrl_c, 5'b11110);
    cyc(1);
    check("k21_ctrl_a", ctrl_a, 4'b0000);
    check("k21_seg_a", seg_a, 8'h00);
    check("k21_ctrl_c", ctrl_c, 5'b11101);
    cyc(4);
    check("k25_ctrl_a", ctrl_a, 4'b0010);
    check("k25_seg_a", seg_a, 8'hFC);

    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'h13;
    cyc(1);
    wr_en = 1'b0;
    cyc(14);
    check("k40_seg_a", seg_a, 8'hFC);
    cyc(4);
    check("k44_ctrl_a", ctrl_a, 4'b0000);
    cyc(1);
    check("k45_ctrl_a", ctrl_a, 4'b0100);
    check("k45_seg_a", seg_a, 8'hF3);
    check("k45_seg_b", seg_b, 8'h0C);
    cyc(15);
    check("k60_seg_a", seg_a, 8'hF3);
    cyc(1);
    check("k61_seg_a", seg_a, 8'h00);
    cyc(4);
    check("k65_ctrl_a", ctrl_a, 4'b1000);
    check("k65_seg_a", seg_a, 8'hFC);
    cyc(14);
    check("k79_tick_a", tick_a, 1'b0);
    cyc(1);
    check("k80_tick_a", tick_a, 1'b1);
    check("k80_ctrl_a", ctrl_a, 4'b1000);
    cyc(1);
    check("k81_tick_a", tick_a, 1'b0);
    check("k81_ctrl_a", ctrl_a, 4'b0000);

    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'h08;
    cyc(1);
    wr_en = 1'b0;
    cyc(24);
    check("k106_ctrl_a", ctrl_a, 4'b0010);
    check("k106_seg_a", seg_a, 8'hFE);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'h0F;
    cyc(1);
    wr_en = 1'b0;
    check("live_wr_edge1", seg_a, 8'hFE);
    cyc(1);
    check("live_wr_edge2", seg_a, 8'h8E);

    wr_en_c = 1'b1; wr_addr_c = 3'd5; wr_data_c = 5'h1F;
    cyc(1);
    wr_en_c = 1'b0;
    bad_c = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (seg_c !== 8'hFC) bad_c++;
      if ($countones(~ctrl_c) != 1) bad_c++;
    end
    check("oob_write_ignored", bad_c, 0);
    wr_en_c = 1'b1; wr_addr_c = 3'd4; wr_data_c = 5'h01;
    cyc(1);
    wr_en_c = 1'b0;
    cyc(70);
    check("k280_ctrl_c", ctrl_c, 5'b10111);
    check("k280_seg_c", seg_c, 8'hFC);
    cyc(1);
    check("k281_ctrl_c", ctrl_c, 5'b01111);
    check("k281_seg_c", seg_c, 8'h60);

    n_ticks = 0; bad_tick = 0; multi = 0; bad_blank = 0; prev_tick = 0;
    for (int i = 0; i < 240; i++) begin
      cyc(1);
      if (tick_a) begin
        n_ticks++;
        if (k % 80 != 0) bad_tick++;
      end else if (k % 80 == 0) begin
        bad_tick++;
      end
      if ($countones(ctrl_a) > 1) multi++;
      if (prev_tick != 0 && ctrl_a !== 4'b0000) bad_blank++;
      prev_tick = int'(tick_a);
    end
    check("frame_tick_count", n_ticks, 3);
    check("frame_tick_period", bad_tick, 0);
    check("ctrl_onehot", multi, 0);
    check("tick_then_blank", bad_blank, 0);

    cyc(30);
    check("k551_ctrl_b", ctrl_b, 4'b1000);
    check("k551_seg_b", seg_b, 8'h03);
    #2 rst = 1'b1;
    #1;
    check("async_seg_b", seg_b, 8'hFF);
    check("async_ctrl_b", ctrl_b, 4'b0000);
    check("async_seg_a", seg_a, 8'h00);
    check("async_ctrl_c", ctrl_c, 5'b11111);
    cyc(2);
    rst = 1'b0;
    k = 0;
    cyc(4);
    check("re_blank_seg_b", seg_b, 8'hFF);
    check("re_blank_ctrl_b", ctrl_b, 4'b0000);
    cyc(1);
    check("re_k5_seg_b", seg_b, 8'h03);
    check("re_k5_ctrl_b", ctrl_b, 4'b0001);
    cyc(20);
    check("re_k25_ctrl_a", ctrl_a, 4'b0010);
    check("re_k25_seg_a", seg_a, 8'hFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
